// File: rtl/instr_fetch.sv
// Instruction fetch sequencer for an asynchronous program RAM: times the
// address/notOE setup, notCE strobe and hold, and hands out whole instructions.
module instr_fetch #(
   parameter int unsigned               ADDR_W    = 54,
   parameter int unsigned               DATA_W    = 64,
   parameter logic [ADDR_W-1:0]         RESET_PC  = '0,
   parameter int unsigned               SETUP_CYC = 3,
   parameter int unsigned               ACC_CYC   = 3,
   parameter int unsigned               HOLD_CYC  = 3,
   parameter int unsigned               OPC_MSB   = 63,
   parameter int unsigned               OPC_LSB   = 56,
   parameter logic [OPC_MSB-OPC_LSB:0]  IMM_OPC   = 8'hC3
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] Address_bus,
   output logic              notCE,
   output logic              notOE,
   input  logic [DATA_W-1:0] Data_bus,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] imm,
   output logic              has_imm,
   output logic [ADDR_W-1:0] instr_pc
);

   localparam int unsigned CNT_MAX =
      (SETUP_CYC > ACC_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                            : ((ACC_CYC > HOLD_CYC) ? ACC_CYC : HOLD_CYC);
   localparam int unsigned CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0]  C_SETUP = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0]  C_ACC   = CNT_W'(ACC_CYC - 1);
   localparam logic [CNT_W-1:0]  C_HOLD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RECOVER,
      ST_OUT
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_ce_n;
   logic                r_oe_n;
   logic                r_phase;
   logic                r_pend;
   logic [ADDR_W-1:0]   r_pend_pc;
   logic                r_valid;
   logic [DATA_W-1:0]   r_instr;
   logic [DATA_W-1:0]   r_imm;
   logic                r_has_imm;
   logic [ADDR_W-1:0]   r_ipc;

   logic                w_redir_any;
   logic [ADDR_W-1:0]   w_redir_tgt;
   logic                w_is_imm;
   logic [ADDR_W-1:0]   w_pc_inc;
   logic [ADDR_W-1:0]   w_ipc;

   // A redirect arriving on the same edge as a pending one takes precedence.
   assign w_redir_any = redirect_valid | r_pend;
   assign w_redir_tgt = redirect_valid ? redirect_pc : r_pend_pc;
   assign w_is_imm    = (r_instr[OPC_MSB:OPC_LSB] == IMM_OPC);
   assign w_pc_inc    = r_pc + PC_ONE;
   assign w_ipc       = r_pc - ADDR_W'(r_phase);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_pc      <= RESET_PC;
         r_addr    <= RESET_PC;
         r_ce_n    <= 1'b1;
         r_oe_n    <= 1'b1;
         r_phase   <= 1'b0;
         r_pend    <= 1'b0;
         r_pend_pc <= '0;
         r_valid   <= 1'b0;
         r_instr   <= '0;
         r_imm     <= '0;
         r_has_imm <= 1'b0;
         r_ipc     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_pc    <= redirect_valid ? redirect_pc : r_pc;
               r_addr  <= redirect_valid ? redirect_pc : r_pc;
               r_phase <= 1'b0;
               r_pend  <= 1'b0;
               r_ce_n  <= 1'b1;
               r_oe_n  <= 1'b0;
               r_cnt   <= C_SETUP;
               r_state <= ST_SETUP;
            end
            ST_SETUP: begin
               r_ce_n <= 1'b1;
               r_oe_n <= 1'b0;
               if (redirect_valid) begin
                  r_pc    <= redirect_pc;
                  r_addr  <= redirect_pc;
                  r_phase <= 1'b0;
                  r_cnt   <= C_SETUP;
               end else if (r_cnt == '0) begin
                  r_ce_n  <= 1'b0;
                  r_cnt   <= C_ACC;
                  r_state <= ST_ACCESS;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ST_ACCESS: begin
               if (redirect_valid) begin
                  r_pend    <= 1'b1;
                  r_pend_pc <= redirect_pc;
               end
               if (r_cnt == '0) begin
                  if (!w_redir_any) begin
                     if (r_phase) begin
                        r_imm <= Data_bus;
                     end else begin
                        r_instr <= Data_bus;
                        r_imm   <= '0;
                     end
                  end
                  r_ce_n  <= 1'b1;
                  r_cnt   <= C_HOLD;
                  r_state <= ST_RECOVER;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ST_RECOVER: begin
               if (redirect_valid) begin
                  r_pend    <= 1'b1;
                  r_pend_pc <= redirect_pc;
               end
               if (r_cnt == '0) begin
                  if (w_redir_any) begin
                     r_pc    <= w_redir_tgt;
                     r_addr  <= w_redir_tgt;
                     r_phase <= 1'b0;
                     r_pend  <= 1'b0;
                     r_cnt   <= C_SETUP;
                     r_state <= ST_SETUP;
                  end else if (!r_phase && w_is_imm) begin
                     r_pc    <= w_pc_inc;
                     r_addr  <= w_pc_inc;
                     r_phase <= 1'b1;
                     r_cnt   <= C_SETUP;
                     r_state <= ST_SETUP;
                  end else begin
                     r_has_imm <= r_phase;
                     r_ipc     <= w_ipc;
                     r_valid   <= 1'b1;
                     r_oe_n    <= 1'b1;
                     r_state   <= ST_OUT;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ST_OUT: begin
               r_ce_n <= 1'b1;
               if (redirect_valid) begin
                  r_pc    <= redirect_pc;
                  r_addr  <= redirect_pc;
                  r_phase <= 1'b0;
                  r_valid <= 1'b0;
                  r_oe_n  <= 1'b0;
                  r_cnt   <= C_SETUP;
                  r_state <= ST_SETUP;
               end else if (instr_ready) begin
                  r_pc    <= w_pc_inc;
                  r_addr  <= w_pc_inc;
                  r_phase <= 1'b0;
                  r_valid <= 1'b0;
                  r_oe_n  <= 1'b0;
                  r_cnt   <= C_SETUP;
                  r_state <= ST_SETUP;
               end
            end
            default: begin
               r_ce_n  <= 1'b1;
               r_oe_n  <= 1'b1;
               r_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign Address_bus = r_addr;
   assign notCE       = r_ce_n;
   assign notOE       = r_oe_n;
   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign imm         = r_imm;
   assign has_imm     = r_has_imm;
   assign instr_pc    = r_ipc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: RAM model with strobe timing monitor, directed vector
// table, multi-cycle corner sequences and a randomized run against a stream model.
module tb_instr_fetch;

   localparam int unsigned AW  = 54;
   localparam int unsigned DW  = 64;
   localparam int unsigned S   = 3;
   localparam int unsigned A   = 3;
   localparam int unsigned H   = 3;
   localparam logic [7:0]  IMM = 8'hC3;
   localparam logic [AW-1:0] AONES = '1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] Address_bus;
   logic          notCE, notOE;
   logic [DW-1:0] Data_bus = '0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic [DW-1:0] instr, imm;
   logic          has_imm;
   logic [AW-1:0] instr_pc;

   instr_fetch #(
      .ADDR_W(AW), .DATA_W(DW), .RESET_PC('0),
      .SETUP_CYC(S), .ACC_CYC(A), .HOLD_CYC(H),
      .OPC_MSB(63), .OPC_LSB(56), .IMM_OPC(IMM)
   ) dut (
      .clk(clk), .rst_n(rst_n), .Address_bus(Address_bus), .notCE(notCE),
      .notOE(notOE), .Data_bus(Data_bus), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .imm(imm), .has_imm(has_imm),
      .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   // RAM contents: explicit overrides, otherwise a fixed hash of the address.
   logic [DW-1:0] ovr [logic [AW-1:0]];

   function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
      logic [63:0] h;
      if (ovr.exists(a)) return ovr[a];
      h = {10'b0, a} * 64'h9E37_79B9_7F4A_7C15;
      h = h ^ (h >> 29);
      if (h[3:0] < 4'd5) h[63:56] = IMM;
      else if (h[63:56] == IMM) h[56] = ~h[56];
      return h;
   endfunction

   always @(negedge clk)
      Data_bus = (!notCE && !notOE) ? ram_rd(Address_bus) : 64'hBAD0_BAD0_BAD0_BAD0;

   // Strobe timing monitor (setup, width, hold, no address motion under CE).
   logic [AW-1:0] p_addr;
   logic          p_oe = 1'b1, p_ce = 1'b1;
   int            stable = 0, lowlen = 0, hi = H;
   int            mon_viol = 0, mon_strobes = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         stable = 0; lowlen = 0; hi = H;
      end else begin
         if (Address_bus !== p_addr || notOE !== p_oe) begin
            if (!notCE || !p_ce) begin
               mon_viol++; $display("timing violation: address/notOE moved under strobe at %0t", $time);
            end
            if (hi < H) begin
               mon_viol++; $display("timing violation: hold %0d at %0t", hi, $time);
            end
            stable = 0;
         end else begin
            stable++;
         end
         if (p_ce && !notCE) begin
            mon_strobes++;
            if (stable < S) begin
               mon_viol++; $display("timing violation: setup %0d at %0t", stable, $time);
            end
            lowlen = 0;
         end
         if (!notCE) lowlen++;
         if (!p_ce && notCE) begin
            if (lowlen != A) begin
               mon_viol++; $display("timing violation: width %0d at %0t", lowlen, $time);
            end
            hi = 0;
         end
         if (notCE) hi++;
      end
      p_addr = Address_bus; p_oe = notOE; p_ce = notCE;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
      repeat (3) tick();
   endtask

   // Counts edges (already at n) until instr_valid, bounded.
   task automatic wait_valid(inout int n, input int budget);
      while (!instr_valid && n < budget) begin
         tick();
         n++;
      end
   endtask

   typedef struct {
      logic          use_redir;
      logic [AW-1:0] pc;
      logic [DW-1:0] w0;
      logic [DW-1:0] w1;
      int            lat;
      logic          has;
      logic [DW-1:0] imm;
      logic [AW-1:0] next;
   } vec_t;

   vec_t vt[7];

   function automatic logic [AW-1:0] pick_target();
      if ($urandom_range(0, 3) == 0) return AONES - AW'($urandom_range(0, 3));
      return AW'($urandom_range(0, 255));
   endfunction

   initial begin
      int            n;
      int            low;
      int            acc;
      logic [AW-1:0] p1;
      logic [AW-1:0] exp_pc;
      logic [DW-1:0] w;
      logic          e_has;
      logic          redir;
      logic [AW-1:0] tgt;

      vt[0] = '{1'b0, '0,            {8'h11, 56'h0011_2233_4455_66}, 64'h7,     10, 1'b0, 64'h0,     AW'(1)};
      vt[1] = '{1'b0, '0,            {IMM,   56'h0000_0000_0000_AA}, 64'h5,     19, 1'b1, 64'h5,     AW'(2)};
      vt[2] = '{1'b1, AW'('h20),     {8'h42, 56'h1234_5678_9ABC_DE}, 64'h9,     10, 1'b0, 64'h0,     AW'('h21)};
      vt[3] = '{1'b1, AONES,         {8'h07, 56'hFFFF_0000_FFFF_00}, 64'h1,     10, 1'b0, 64'h0,     AW'(0)};
      vt[4] = '{1'b1, AONES,         {IMM,   56'h0101_0101_0101_01}, 64'hFEED,  19, 1'b1, 64'hFEED,  AW'(1)};
      vt[5] = '{1'b1, AW'('h1234),   {8'hC2, 56'h5555_5555_5555_55}, 64'h3,     10, 1'b0, 64'h0,     AW'('h1235)};
      vt[6] = '{1'b1, AW'('h300),    {IMM,   56'h0000_0000_0000_01}, 64'h0,     19, 1'b1, 64'h0,     AW'('h302)};

      hold_reset();
      check("reset_notCE", {63'b0, notCE}, 64'd1);
      check("reset_notOE", {63'b0, notOE}, 64'd1);
      check("reset_valid", {63'b0, instr_valid}, 64'd0);
      check("reset_addr", {10'b0, Address_bus}, 64'd0);
      check("reset_instr", instr, 64'd0);
      check("reset_ipc", {10'b0, instr_pc}, 64'd0);

      for (int i = 0; i < 7; i++) begin
         ovr.delete();
         p1 = vt[i].pc + AW'(1);
         ovr[vt[i].pc] = vt[i].w0;
         ovr[p1] = vt[i].w1;
         hold_reset();
         rst_n = 1'b1;
         redirect_valid = vt[i].use_redir;
         redirect_pc = vt[i].pc;
         tick();
         n = 1;
         redirect_valid = 1'b0;
         wait_valid(n, 40);
         check($sformatf("v%0d_latency", i), 64'(n), 64'(vt[i].lat));
         check($sformatf("v%0d_instr", i), instr, vt[i].w0);
         check($sformatf("v%0d_has_imm", i), {63'b0, has_imm}, {63'b0, vt[i].has});
         check($sformatf("v%0d_imm", i), imm, vt[i].imm);
         check($sformatf("v%0d_ipc", i), {10'b0, instr_pc}, {10'b0, vt[i].pc});
         check($sformatf("v%0d_out_strobes", i), {62'b0, notCE, notOE}, 64'd3);
         instr_ready = 1'b1;
         tick();
         instr_ready = 1'b0;
         check($sformatf("v%0d_valid_drop", i), {63'b0, instr_valid}, 64'd0);
         check($sformatf("v%0d_next_addr", i), {10'b0, Address_bus}, {10'b0, vt[i].next});
         check($sformatf("v%0d_next_oe", i), {63'b0, notOE}, 64'd0);
      end

      // Reset mid-ACCESS, then restart from the reset address.
      ovr.delete();
      ovr[AW'(0)] = {8'h21, 56'hAAAA_BBBB_CCCC_DD};
      ovr[AW'(1)] = {8'h22, 56'h1111_2222_3333_44};
      ovr[AW'('h20)] = {8'h23, 56'h0F0F_0F0F_0F0F_0F};
      ovr[AW'('h40)] = {8'h24, 56'h7777_6666_5555_44};
      hold_reset();
      rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = AW'('h55);
      tick();
      redirect_valid = 1'b0;
      n = 1;
      while (notCE && n < 20) begin tick(); n++; end
      check("mid_access_reached", {63'b0, notCE}, 64'd0);
      rst_n = 1'b0;
      tick();
      check("midrst_notCE", {63'b0, notCE}, 64'd1);
      check("midrst_notOE", {63'b0, notOE}, 64'd1);
      check("midrst_valid", {63'b0, instr_valid}, 64'd0);
      check("midrst_addr", {10'b0, Address_bus}, 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      n = 1;
      wait_valid(n, 40);
      check("postrst_latency", 64'(n), 64'(S + A + H + 1));
      check("postrst_ipc", {10'b0, instr_pc}, 64'd0);

      // Backpressure: payload, strobes and address frozen.
      for (int k = 0; k < 7; k++) begin
         tick();
         check("bp_valid", {63'b0, instr_valid}, 64'd1);
         check("bp_instr", instr, ram_rd(AW'(0)));
         check("bp_ce", {63'b0, notCE}, 64'd1);
         check("bp_addr", {10'b0, Address_bus}, 64'd0);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("bp_accept_addr", {10'b0, Address_bus}, 64'd1);
      n = 1;
      wait_valid(n, 40);
      check("b2b_latency", 64'(n), 64'(S + A + H + 1));
      check("b2b_ipc", {10'b0, instr_pc}, 64'd1);
      check("b2b_instr", instr, ram_rd(AW'(1)));

      // Redirect while the strobe is low.
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      n = 1;
      while (notCE && n < 20) begin tick(); n++; end
      redirect_valid = 1'b1; redirect_pc = AW'('h20);
      low = 1;
      tick();
      redirect_valid = 1'b0;
      while (!notCE && low < 10) begin low++; tick(); end
      check("redir_access_width", 64'(low), 64'(A));
      n = 0;
      wait_valid(n, 60);
      check("redir_access_ipc", {10'b0, instr_pc}, 64'h20);
      check("redir_access_instr", instr, ram_rd(AW'('h20)));

      // Redirect together with ready in OUT drops the presented instruction.
      instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = AW'('h40);
      tick();
      instr_ready = 1'b0; redirect_valid = 1'b0;
      check("redir_out_valid", {63'b0, instr_valid}, 64'd0);
      check("redir_out_addr", {10'b0, Address_bus}, 64'h40);
      n = 1;
      wait_valid(n, 40);
      check("redir_out_latency", 64'(n), 64'(S + A + H + 1));
      check("redir_out_ipc", {10'b0, instr_pc}, 64'h40);
      check("redir_out_instr", instr, ram_rd(AW'('h40)));

      // Randomized run against the delivered-instruction stream model.
      ovr.delete();
      hold_reset();
      rst_n = 1'b1;
      exp_pc = '0;
      acc = 0;
      for (int c = 0; c < 3000; c++) begin
         redir = ($urandom_range(0, 99) < 3);
         tgt = pick_target();
         redirect_valid = redir;
         redirect_pc = tgt;
         instr_ready = $urandom_range(0, 1) == 1;
         if (instr_valid && instr_ready && !redir) begin
            w = ram_rd(exp_pc);
            e_has = (w[63:56] == IMM);
            check("rnd_ipc", {10'b0, instr_pc}, {10'b0, exp_pc});
            check("rnd_instr", instr, w);
            check("rnd_has_imm", {63'b0, has_imm}, {63'b0, e_has});
            check("rnd_imm", imm, e_has ? ram_rd(exp_pc + AW'(1)) : 64'd0);
            exp_pc = exp_pc + (e_has ? AW'(2) : AW'(1));
            acc++;
         end
         if (redir) exp_pc = tgt;
         tick();
      end
      redirect_valid = 1'b0;
      instr_ready = 1'b0;
      check("rnd_deliveries", {63'b0, acc > 20}, 64'd1);

      tick(); tick();
      check("strobes_seen", {63'b0, mon_strobes > 100}, 64'd1);
      check("timing_violations", 64'(mon_viol), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected end before 1000000", $time);
      $fatal(1);
   end

endmodule
